// File: rtl/counter_pkg.sv
// Shared defaults and helpers for the mod-N counter chain.
// Optional feature macro: CNT_LOAD_EN (parallel load ports on the top level).
package counter_pkg;

   localparam int unsigned W_DEF      = 4;
   localparam int unsigned MOD_DEF    = 13;
   localparam int unsigned DIGITS_DEF = 2;

`ifdef CNT_LOAD_EN
   localparam bit LOAD_EN_DEF = 1'b1;
`else
   localparam bit LOAD_EN_DEF = 1'b0;
`endif

   // Digit value after which the next digit steps: MOD-1 counting up, 0 counting down.
   function automatic int unsigned term_val(input int unsigned mod, input logic up);
      return up ? (mod - 1) : 0;
   endfunction

endpackage

// File: rtl/counter_digit.sv
// One W-bit modulo-MOD digit register with clear, load and up/down step.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_step            advance this digit by one in direction i_up
//   i_up              1 = increment, 0 = decrement
//   i_clr             synchronous clear (highest priority after reset)
//   i_ld, i_ld_val    synchronous load; out-of-range values load as 0
//   o_q               registered digit value
//   o_at_term         digit sits at its terminal value for the current direction
module counter_digit
   import counter_pkg::*;
#(
   parameter int unsigned W   = W_DEF,
   parameter int unsigned MOD = MOD_DEF
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_step,
   input  logic         i_up,
   input  logic         i_clr,
   input  logic         i_ld,
   input  logic [W-1:0] i_ld_val,
   output logic [W-1:0] o_q,
   output logic         o_at_term
);

   // One extra bit so MOD == 2**W is representable.
   localparam logic [W:0]   MOD_X = (W+1)'(MOD);
   localparam logic [W-1:0] MAX_V = W'(MOD - 1);

   logic [W-1:0] r_q;
   logic [W-1:0] w_nxt;
   logic [W-1:0] w_ld_fix;

   assign o_q       = r_q;
   assign o_at_term = (r_q == W'(term_val(MOD, i_up)));

   // Step value; out-of-range values recover to a legal value in one step.
   always_comb begin
      w_nxt = r_q;
      if (i_up) begin
         w_nxt = (r_q >= MAX_V) ? '0 : r_q + W'(1);
      end else begin
         w_nxt = ((r_q == '0) || ({1'b0, r_q} >= MOD_X)) ? MAX_V : r_q - W'(1);
      end
   end

   assign w_ld_fix = ({1'b0, i_ld_val} >= MOD_X) ? '0 : i_ld_val;

   // Digit register: reset > clear > load > step.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_q <= '0;
      else if (i_clr)  r_q <= '0;
      else if (i_ld)   r_q <= w_ld_fix;
      else if (i_step) r_q <= w_nxt;
   end

endmodule

// File: rtl/counter_modn_chain.sv
// Cascade of DIGITS modulo-MOD digits with enable, direction, clear,
// optional parallel load and a combinational terminal-count output.
// Optional feature macro: CNT_LOAD_EN adds LOAD / LD_VAL.
// Ports:
//   CLK, RST     clock (rising edge), async active-high reset
//   EN, UP       count enable, direction (1 = up)
//   CLR          synchronous clear
//   LOAD, LD_VAL synchronous parallel load (CNT_LOAD_EN only)
//   CNT          registered count, digit i in bits [i*W +: W]
//   TC           combinational terminal count / carry-borrow out
module counter_modn_chain
   import counter_pkg::*;
#(
   parameter int unsigned W      = W_DEF,
   parameter int unsigned MOD    = MOD_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                UP,
   input  logic                CLR,
`ifdef CNT_LOAD_EN
   input  logic                LOAD,
   input  logic [DIGITS*W-1:0] LD_VAL,
`endif
   output logic [DIGITS*W-1:0] CNT,
   output logic                TC
);

   logic [DIGITS:0]     w_carry;
   logic [DIGITS-1:0]   w_at_term;
   logic                w_load;
   logic [DIGITS*W-1:0] w_ld_val;

`ifdef CNT_LOAD_EN
   assign w_load   = LOAD;
   assign w_ld_val = LD_VAL;
`else
   assign w_load   = 1'b0;
   assign w_ld_val = '0;
`endif

   // Ripple of step enables: digit i steps when EN and all lower digits are terminal.
   assign w_carry[0] = EN;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      counter_digit #(
         .W   (W),
         .MOD (MOD)
      ) u_digit (
         .i_clk     (CLK),
         .i_rst     (RST),
         .i_step    (w_carry[g]),
         .i_up      (UP),
         .i_clr     (CLR),
         .i_ld      (w_load),
         .i_ld_val  (w_ld_val[g*W +: W]),
         .o_q       (CNT[g*W +: W]),
         .o_at_term (w_at_term[g])
      );
      assign w_carry[g+1] = w_carry[g] & w_at_term[g];
   end

   assign TC = w_carry[DIGITS] & ~CLR & ~w_load;

endmodule

// File: tb/tb_counter_modn_chain.sv
// Directed self-checking bench for counter_modn_chain (W=4, MOD=13, DIGITS=2).
module tb_counter_modn_chain;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       EN  = 1'b0;
   logic       UP  = 1'b1;
   logic       CLR = 1'b0;
`ifdef CNT_LOAD_EN
   logic       LOAD   = 1'b0;
   logic [7:0] LD_VAL = 8'h00;
`endif
   logic [7:0] CNT;
   logic       TC;

   int checks   = 0;
   int failures = 0;

   counter_modn_chain #(.W(4), .MOD(13), .DIGITS(2)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .UP     (UP),
      .CLR    (CLR),
`ifdef CNT_LOAD_EN
      .LOAD   (LOAD),
      .LD_VAL (LD_VAL),
`endif
      .CNT    (CNT),
      .TC     (TC)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, return on the following falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      // Reset and first count
      tick(2);
      chk("reset_cnt", 32'(CNT), 32'h00);
      RST = 1'b0; EN = 1'b1; UP = 1'b1;
      tick(1);
      chk("first_edge", 32'(CNT), 32'h01);
      tick(3);
      chk("count_4", 32'(CNT), 32'h04);
      #2 RST = 1'b1;
      #1 chk("async_reset", 32'(CNT), 32'h00);
      @(negedge CLK);
      chk("reset_held", 32'(CNT), 32'h00);
      RST = 1'b0;
      tick(1);
      chk("after_release", 32'(CNT), 32'h01);

      // Up wrap over the full 169-state period
      CLR = 1'b1; tick(1); CLR = 1'b0;
      chk("clr_to_zero", 32'(CNT), 32'h00);
      tick(168);
      chk("up_top_cnt", 32'(CNT), 32'hCC);
      #1 chk("up_top_tc", 32'(TC), 32'h1);
      tick(1);
      chk("up_wrap_cnt", 32'(CNT), 32'h00);
      chk("up_wrap_tc", 32'(TC), 32'h0);
      tick(12);
      chk("digit0_top", 32'(CNT), 32'h0C);
      tick(1);
      chk("digit1_step", 32'(CNT), 32'h10);

      // Down direction
      UP = 1'b0;
      #1 chk("down_tc_low", 32'(TC), 32'h0);
      tick(1);
      chk("down_borrow", 32'(CNT), 32'h0C);
      tick(12);
      chk("down_zero_cnt", 32'(CNT), 32'h00);
      #1 chk("down_zero_tc", 32'(TC), 32'h1);
      tick(1);
      chk("down_wrap", 32'(CNT), 32'hCC);

      // Clear priority and TC masking
      UP = 1'b1; CLR = 1'b1;
      #1 chk("clr_masks_tc", 32'(TC), 32'h0);
      tick(1);
      CLR = 1'b0;
      chk("clr_from_cc", 32'(CNT), 32'h00);
      tick(72);
      chk("reach_57", 32'(CNT), 32'h57);
      CLR = 1'b1;
`ifdef CNT_LOAD_EN
      LOAD = 1'b1; LD_VAL = 8'h33;
`endif
      tick(1);
      CLR = 1'b0;
`ifdef CNT_LOAD_EN
      LOAD = 1'b0;
`endif
      chk("clr_priority", 32'(CNT), 32'h00);

      // Hold with EN low
      tick(72);
      EN = 1'b0;
      tick(5);
      chk("hold_cnt", 32'(CNT), 32'h57);
      chk("hold_tc", 32'(TC), 32'h0);

      // Direction flip at 0xC0
      EN = 1'b1;
      tick(84);
      chk("reach_c0", 32'(CNT), 32'hC0);
      UP = 1'b0;
      tick(1);
      chk("flip_down", 32'(CNT), 32'hBC);

`ifdef CNT_LOAD_EN
      // Parallel load
      UP = 1'b1; LOAD = 1'b1; LD_VAL = 8'hCC;
      tick(1);
      chk("load_cc", 32'(CNT), 32'hCC);
      #1 chk("load_masks_tc", 32'(TC), 32'h0);
      LD_VAL = 8'hBC;
      tick(1);
      chk("load_bc", 32'(CNT), 32'hBC);
      LOAD = 1'b0;
      tick(1);
      chk("step_after_load", 32'(CNT), 32'hC0);
      LOAD = 1'b1; LD_VAL = 8'hF3;
      tick(1);
      LOAD = 1'b0;
      chk("load_out_of_range", 32'(CNT), 32'h03);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
